// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the EX-stage divider.
package cpu_pkg;

    localparam int WIDTH    = 32;
    localparam int DIV_ITER = 32;

    // HI/LO write-enable encoding consumed by the EX/MEM register
    localparam logic [1:0] HILO_NONE = 2'b00;
    localparam logic [1:0] HILO_BOTH = 2'b11;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem, quo} left, then subtract
// the divisor magnitude when it fits and record the quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    // One extra bit so the shifted remainder never overflows before the compare
    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        if (shifted >= {1'b0, divisor}) begin
            rem_next = shifted[WIDTH-1:0] - divisor;
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: one quotient bit per cycle on operand magnitudes,
// signs restored on the final step so HI/LO are registered when ready_o rises.
module div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = cpu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] HI_data_o,
    output logic [WIDTH-1:0] LO_data_o,
    output logic [1:0]       writeHILO_o,
    output logic             divByZero_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    div_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] rem, rem_next, quo, quo_next, dvsr, dvsr_next;
    logic [WIDTH-1:0] hi_q, hi_next, lo_q, lo_next;
    logic [WIDTH-1:0] step_rem, step_quo, dd_mag, dv_mag;
    logic             q_neg, q_neg_next, r_neg, r_neg_next;
    logic             busy_q, ready_q, dbz_q, dbz_next;
    logic [1:0]       hilo_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvsr),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    assign dd_mag = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    assign dv_mag = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= DIV_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rem_next   = rem;
        quo_next   = quo;
        dvsr_next  = dvsr;
        q_neg_next = q_neg;
        r_neg_next = r_neg;
        hi_next    = hi_q;
        lo_next    = lo_q;
        dbz_next   = 1'b0;
        case (state)
            DIV_IDLE, DIV_DONE: begin
                state_next = DIV_IDLE;
                if (start_i) begin
                    if (divisor_i == '0) begin
                        state_next = DIV_DONE;
                        hi_next    = dividend_i;
                        lo_next    = '1;
                        dbz_next   = 1'b1;
                    end else begin
                        state_next = DIV_CALC;
                        rem_next   = '0;
                        quo_next   = dd_mag;
                        dvsr_next  = dv_mag;
                        cnt_next   = '0;
                        q_neg_next = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                        r_neg_next = signed_i & dividend_i[WIDTH-1];
                    end
                end
            end
            DIV_CALC: begin
                rem_next = step_rem;
                quo_next = step_quo;
                cnt_next = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_next = DIV_DONE;
                    lo_next    = q_neg ? -step_quo : step_quo;
                    hi_next    = r_neg ? -step_rem : step_rem;
                end
            end
            default: state_next = DIV_IDLE;
        endcase
        // A flush wins over everything and must leave the old result untouched
        if (cancel_i) begin
            state_next = DIV_IDLE;
            hi_next    = hi_q;
            lo_next    = lo_q;
            dbz_next   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            hilo_q  <= HILO_NONE;
        end else begin
            cnt     <= cnt_next;
            rem     <= rem_next;
            quo     <= quo_next;
            dvsr    <= dvsr_next;
            q_neg   <= q_neg_next;
            r_neg   <= r_neg_next;
            hi_q    <= hi_next;
            lo_q    <= lo_next;
            dbz_q   <= dbz_next;
            busy_q  <= (state_next == DIV_CALC);
            ready_q <= (state_next == DIV_DONE);
            hilo_q  <= (state_next == DIV_DONE) ? HILO_BOTH : HILO_NONE;
        end
    end

    assign busy_o      = busy_q;
    assign ready_o     = ready_q;
    assign HI_data_o   = hi_q;
    assign LO_data_o   = lo_q;
    assign writeHILO_o = hilo_q;
    assign divByZero_o = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed, table-driven bench for div_unit with hand-written cancel,
// back-to-back and asynchronous-reset sequences.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic        cancel_i = 1'b0;
    logic        busy_o, ready_o, divByZero_o;
    logic [31:0] HI_data_o, LO_data_o;
    logic [1:0]  writeHILO_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .cancel_i    (cancel_i),
        .busy_o      (busy_o),
        .ready_o     (ready_o),
        .HI_data_o   (HI_data_o),
        .LO_data_o   (LO_data_o),
        .writeHILO_o (writeHILO_o),
        .divByZero_o (divByZero_o)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Holds the request across exactly one rising edge (E0)
    task automatic apply_stimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        start_i    = 1'b1;
        signed_i   = sgn;
        dividend_i = a;
        divisor_i  = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // lat counts edges from E0 to the first sample with ready_o high
    task automatic wait_ready(output int lat, output int busy_cnt);
        lat = 1;
        busy_cnt = 0;
        while (!ready_o && lat < 40) begin
            if (busy_o) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (ready_o) pulses++;
        end
    endtask

    initial begin
        int lat, bc, pulses;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0, 33};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 33};
        vecs[3] = '{1'b0, 32'd5,          32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1};
        vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 33};
        vecs[5] = '{1'b0, 32'hFFFFFFFF,   32'd3,        32'h55555555, 32'd0,        1'b0, 33};
        vecs[6] = '{1'b0, 32'd3,          32'd10,       32'd0,        32'd3,        1'b0, 33};
        vecs[7] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 33};
        vecs[8] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 33};
        vecs[9] = '{1'b1, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1};

        #12;
        check_output("reset busy", busy_o, 0);
        check_output("reset ready", ready_o, 0);
        check_output("reset hilo", writeHILO_o, 0);
        check_output("reset dbz", divByZero_o, 0);
        check_output("reset hi", HI_data_o, 0);
        check_output("reset lo", LO_data_o, 0);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            apply_stimulus(vecs[i].sgn, vecs[i].a, vecs[i].b);
            wait_ready(lat, bc);
            check_output($sformatf("v%0d latency", i), lat, vecs[i].lat);
            check_output($sformatf("v%0d ready", i), ready_o, 1);
            check_output($sformatf("v%0d lo", i), LO_data_o, vecs[i].lo);
            check_output($sformatf("v%0d hi", i), HI_data_o, vecs[i].hi);
            check_output($sformatf("v%0d hilo", i), writeHILO_o, 2'b11);
            check_output($sformatf("v%0d dbz", i), divByZero_o, vecs[i].dbz);
            check_output($sformatf("v%0d busy cycles", i), bc, vecs[i].dbz ? 0 : 32);
            @(posedge clk);
            #1;
            check_output($sformatf("v%0d ready pulse", i), ready_o, 0);
            check_output($sformatf("v%0d hilo pulse", i), writeHILO_o, 0);
        end

        // Flush at iteration 10 of a long divide
        @(negedge clk);
        apply_stimulus(1'b0, 32'hFFFFFFFF, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        check_output("pre-cancel busy", busy_o, 1);
        @(negedge clk);
        cancel_i = 1'b1;
        @(posedge clk);
        #1;
        cancel_i = 1'b0;
        check_output("cancel busy", busy_o, 0);
        check_output("cancel ready", ready_o, 0);
        count_pulses(40, pulses);
        check_output("cancel no ready", pulses, 0);

        @(negedge clk);
        apply_stimulus(1'b0, 32'd9, 32'd3);
        wait_ready(lat, bc);
        check_output("9/3 latency", lat, 33);
        check_output("9/3 lo", LO_data_o, 3);
        check_output("9/3 hi", HI_data_o, 0);

        // Start issued while ready_o is high: no idle cycle in between
        apply_stimulus(1'b0, 32'd20, 32'd6);
        check_output("b2b busy", busy_o, 1);
        check_output("b2b ready", ready_o, 0);
        wait_ready(lat, bc);
        check_output("20/6 latency", lat, 33);
        check_output("20/6 lo", LO_data_o, 3);
        check_output("20/6 hi", HI_data_o, 2);

        // Asynchronous reset in the middle of CALC
        @(posedge clk);
        @(negedge clk);
        apply_stimulus(1'b0, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_output("arst busy", busy_o, 0);
        check_output("arst ready", ready_o, 0);
        check_output("arst hilo", writeHILO_o, 0);
        check_output("arst dbz", divByZero_o, 0);
        check_output("arst hi", HI_data_o, 0);
        check_output("arst lo", LO_data_o, 0);
        @(negedge clk);
        rst = 1'b1;
        count_pulses(40, pulses);
        check_output("arst no ready", pulses, 0);

        @(negedge clk);
        apply_stimulus(1'b0, 32'd100, 32'd7);
        wait_ready(lat, bc);
        check_output("post-reset lo", LO_data_o, 14);
        check_output("post-reset hi", HI_data_o, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
